// File: rtl/aes_pkg.sv
// Shared AES key-schedule definitions: encodings, FSM states and GF(2^8) helpers.
// The S-box is computed as multiplicative inverse plus affine map, not a lookup table.
package aes_pkg;

  localparam int NB        = 4;
  localparam int WORD_SIZE = 32;

  localparam logic [1:0] KEY_MODE_128     = 2'b00;
  localparam logic [1:0] KEY_MODE_192     = 2'b01;
  localparam logic [1:0] KEY_MODE_256     = 2'b10;
  localparam logic [1:0] KEY_MODE_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_GEN  = 2'b10,
    ST_DONE = 2'b11
  } ks_state_t;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      p = b[k] ? (p ^ x) : p;
      x = xtime(x);
    end
    return p;
  endfunction

  // inverse is b^254 (254 = 8'b1111_1110), zero maps to zero
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] inv;
    logic [7:0] sq;
    inv = 8'h01;
    sq  = b;
    for (int k = 0; k < 8; k++) begin
      inv = (k == 0) ? inv : gf_mul(inv, sq);
      sq  = gf_mul(sq, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [WORD_SIZE-1:0] rot_word(input logic [WORD_SIZE-1:0] w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_sub_word.sv
// SubWord: four parallel S-boxes over a 32-bit word.
module aes_sub_word
  import aes_pkg::*;
(
  input  logic [WORD_SIZE-1:0] word,
  output logic [WORD_SIZE-1:0] subbed
);

  // byte-lane substitution
  always_comb begin
    subbed = {sbox(word[31:24]), sbox(word[23:16]), sbox(word[15:8]), sbox(word[7:0])};
  end

endmodule

// File: rtl/key_schedule_seq.sv
// Sequential AES-128/192/256 key schedule: one expanded word per clock into a
// 60-word store, with a registered 128-bit round-key read port.
module key_schedule_seq
  import aes_pkg::*;
#(
  parameter int MAX_NK = 8,
  parameter int MAX_NR = 14
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [1:0]             key_mode,
  input  logic [32*MAX_NK-1:0]   key_in,
  output logic                   ready,
  output logic                   busy,
  output logic                   done,
  output logic                   keys_valid,
  output logic                   mode_err,
  output logic [3:0]             nr_out,
  input  logic                   rd_en,
  input  logic [3:0]             rd_round,
  output logic [127:0]           rd_data,
  output logic                   rd_hit
);

  localparam int DEPTH = NB * (MAX_NR + 1);

  ks_state_t             state_r, state_s;
  logic [3:0]            nk_r;
  logic [32*MAX_NK-1:0]  key_r;
  logic [5:0]            i_r;
  logic [2:0]            mod_r;
  logic [7:0]            rcon_r;
  logic [WORD_SIZE-1:0]  w_r [DEPTH];

  logic                  accept_s, err_s, finish_s, gen_wr_s;
  logic [5:0]            end_s, rd_base_s;
  logic [2:0]            mod_next_s;
  logic [WORD_SIZE-1:0]  prev_s, sub_in_s, sub_out_s, t_s, new_word_s;

  aes_sub_word u_sub_word (
    .word   (sub_in_s),
    .subbed (sub_out_s)
  );

  // one past the last schedule index; GEN spends that extra cycle signalling done
  assign end_s      = {nr_out, 2'b00} + 6'd4;
  assign gen_wr_s   = (state_r == ST_GEN) && (i_r != end_s);
  assign mod_next_s = ({1'b0, mod_r} == (nk_r - 4'd1)) ? 3'd0 : (mod_r + 3'd1);
  assign rd_base_s  = {rd_round, 2'b00};

  // expansion datapath: the single SubWord serves both the rotated and plain cases
  always_comb begin
    prev_s   = w_r[i_r - 6'd1];
    sub_in_s = (mod_r == 3'd0) ? rot_word(prev_s) : prev_s;
    if (mod_r == 3'd0) begin
      t_s = sub_out_s ^ {rcon_r, 24'h000000};
    end else if ((nk_r == 4'd8) && (mod_r == 3'd4)) begin
      t_s = sub_out_s;
    end else begin
      t_s = prev_s;
    end
    new_word_s = w_r[i_r - {2'b00, nk_r}] ^ t_s;
  end

  // next-state and control strobes
  always_comb begin
    state_s  = state_r;
    accept_s = 1'b0;
    err_s    = 1'b0;
    finish_s = 1'b0;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start && (key_mode == KEY_MODE_ILLEGAL)) begin
          err_s = 1'b1;
        end else if (start) begin
          accept_s = 1'b1;
          state_s  = ST_LOAD;
        end else begin
          state_s = state_r;
        end
      end
      ST_LOAD: state_s = ST_GEN;
      ST_GEN: begin
        if (i_r == end_s) begin
          finish_s = 1'b1;
          state_s  = ST_DONE;
        end else begin
          state_s = ST_GEN;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // control and status registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      ready      <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      keys_valid <= 1'b0;
      mode_err   <= 1'b0;
      nr_out     <= 4'd0;
      nk_r       <= 4'd4;
      key_r      <= '0;
      i_r        <= 6'd0;
      mod_r      <= 3'd0;
      rcon_r     <= 8'h01;
    end else begin
      state_r  <= state_s;
      ready    <= (state_s == ST_IDLE) || (state_s == ST_DONE);
      busy     <= (state_s == ST_LOAD) || (state_s == ST_GEN);
      done     <= finish_s;
      mode_err <= err_s;
      if (accept_s) begin
        key_r      <= key_in;
        keys_valid <= 1'b0;
        case (key_mode)
          KEY_MODE_128: begin nk_r <= 4'd4; nr_out <= 4'd10; end
          KEY_MODE_192: begin nk_r <= 4'd6; nr_out <= 4'd12; end
          KEY_MODE_256: begin nk_r <= 4'd8; nr_out <= 4'd14; end
          default:      begin nk_r <= nk_r; nr_out <= nr_out; end
        endcase
      end else if (finish_s) begin
        keys_valid <= 1'b1;
      end
      if (state_r == ST_LOAD) begin
        i_r    <= {2'b00, nk_r};
        mod_r  <= 3'd0;
        rcon_r <= 8'h01;
      end else if (gen_wr_s) begin
        i_r    <= i_r + 6'd1;
        mod_r  <= mod_next_s;
        rcon_r <= (mod_r == 3'd0) ? xtime(rcon_r) : rcon_r;
      end
    end
  end

  // word store: key words in parallel on LOAD, one derived word per GEN cycle
  always_ff @(posedge clk) begin
    if (rst_n && (state_r == ST_LOAD)) begin
      for (int j = 0; j < MAX_NK; j++) begin
        if (j < int'(nk_r)) begin
          w_r[j] <= key_r[32*MAX_NK-1-32*j -: 32];
        end
      end
    end else if (rst_n && gen_wr_s) begin
      w_r[i_r] <= new_word_s;
    end
  end

  // registered round-key read; holds when idle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data <= 128'd0;
      rd_hit  <= 1'b0;
    end else if (rd_en) begin
      if (keys_valid && (rd_round <= nr_out)) begin
        rd_hit  <= 1'b1;
        rd_data <= {w_r[rd_base_s], w_r[rd_base_s + 6'd1],
                    w_r[rd_base_s + 6'd2], w_r[rd_base_s + 6'd3]};
      end else begin
        rd_hit  <= 1'b0;
        rd_data <= 128'd0;
      end
    end
  end

endmodule

// File: tb/tb_key_schedule_seq.sv
// Self-checking bench for key_schedule_seq: FIPS-197 vector table, read scoreboard,
// and hand-written sequences for timing, illegal mode, reset abort and start collisions.
module tb_key_schedule_seq;

  logic         clk = 1'b0;
  logic         rst_n, start, rd_en;
  logic [1:0]   key_mode;
  logic [255:0] key_in;
  logic [3:0]   rd_round;
  logic         ready, busy, done, keys_valid, mode_err, rd_hit;
  logic [3:0]   nr_out;
  logic [127:0] rd_data;

  always #5 clk = ~clk;

  key_schedule_seq #(.MAX_NK(8), .MAX_NR(14)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .key_mode(key_mode), .key_in(key_in),
    .ready(ready), .busy(busy), .done(done), .keys_valid(keys_valid), .mode_err(mode_err),
    .nr_out(nr_out), .rd_en(rd_en), .rd_round(rd_round), .rd_data(rd_data), .rd_hit(rd_hit)
  );

  typedef struct { logic [1:0] mode; logic [3:0] round; logic hit; logic [127:0] data; } vec_t;
  typedef struct { logic [3:0] round; logic hit; logic [127:0] data; } exp_t;

  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] R128_10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] R128_2  = 128'hf2c295f27a96b9435935807a7359f67f;
  localparam logic [127:0] R192_12 = 128'he98ba06f448c773c8ecc720401002202;

  vec_t vecs[32];
  int   nvec = 0;
  exp_t sb[$];
  int   pass_cnt = 0;
  int   total_cnt = 0;

  task automatic add_vec(input logic [1:0] m, input logic [3:0] r, input logic h, input logic [127:0] d);
    vecs[nvec] = '{mode: m, round: r, hit: h, data: d};
    nvec++;
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // pop one expected read result and compare against the registered port
  task automatic compare_out();
    exp_t e;
    if (sb.size() == 0) begin
      total_cnt++;
      $display("FAIL scoreboard: output with no pending request");
    end else begin
      e = sb.pop_front();
      check($sformatf("rd_hit r%0d", e.round), 128'(rd_hit), 128'(e.hit));
      check($sformatf("rd_data r%0d", e.round), rd_data, e.data);
    end
  endtask

  task automatic read_one(input logic [3:0] r, input logic h, input logic [127:0] d);
    rd_en = 1'b1;
    rd_round = r;
    sb.push_back('{round: r, hit: h, data: d});
    @(posedge clk); #1;
    rd_en = 1'b0;
    compare_out();
  endtask

  // back-to-back reads of every table entry for one mode
  task automatic read_mode(input logic [1:0] m);
    for (int i = 0; i < nvec; i++) begin
      if (vecs[i].mode == m) begin
        rd_en = 1'b1;
        rd_round = vecs[i].round;
        sb.push_back('{round: vecs[i].round, hit: vecs[i].hit, data: vecs[i].data});
        @(posedge clk); #1;
        compare_out();
      end
    end
    rd_en = 1'b0;
  endtask

  // start a load, optionally poke start again at cycle inject_at, time start-to-done
  task automatic load_key(input logic [1:0] m, input logic [255:0] k, input int g,
                          input int inject_at, input string tag);
    int   n;
    logic kv_early;
    start = 1'b1; key_mode = m; key_in = k;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, " busy after start"}, 128'({busy, ready}), 128'(2'b10));
    n = 0;
    kv_early = 1'b0;
    while (done !== 1'b1 && n < 200) begin
      if (n == inject_at) begin
        start = 1'b1; key_mode = 2'b10; key_in = ~k;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      n++;
      if (done !== 1'b1 && keys_valid !== 1'b0) kv_early = 1'b1;
    end
    start = 1'b0;
    check({tag, " start-to-done cycles"}, 128'(n), 128'(g + 2));
    check({tag, " keys_valid early"}, 128'(kv_early), 128'd0);
    check({tag, " keys_valid at done"}, 128'(keys_valid), 128'd1);
    @(posedge clk); #1;
    check({tag, " done pulse width"}, 128'({done, ready, busy}), 128'(3'b010));
  endtask

  initial begin
    add_vec(2'b00, 4'd0,  1'b1, 128'h2b7e151628aed2a6abf7158809cf4f3c);
    add_vec(2'b00, 4'd1,  1'b1, 128'ha0fafe1788542cb123a339392a6c7605);
    add_vec(2'b00, 4'd2,  1'b1, R128_2);
    add_vec(2'b00, 4'd10, 1'b1, R128_10);
    add_vec(2'b00, 4'd11, 1'b0, 128'h0);
    add_vec(2'b00, 4'd15, 1'b0, 128'h0);
    add_vec(2'b01, 4'd0,  1'b1, 128'h8e73b0f7da0e6452c810f32b809079e5);
    add_vec(2'b01, 4'd1,  1'b1, 128'h62f8ead2522c6b7bfe0c91f72402f5a5);
    add_vec(2'b01, 4'd12, 1'b1, R192_12);
    add_vec(2'b01, 4'd13, 1'b0, 128'h0);
    add_vec(2'b10, 4'd0,  1'b1, 128'h603deb1015ca71be2b73aef0857d7781);
    add_vec(2'b10, 4'd1,  1'b1, 128'h1f352c073b6108d72d9810a30914dff4);
    add_vec(2'b10, 4'd2,  1'b1, 128'h9ba354118e6925afa51a8b5f2067fcde);
    add_vec(2'b10, 4'd14, 1'b1, 128'hfe4890d1e6188d0b046df344706c631e);
    add_vec(2'b10, 4'd15, 1'b0, 128'h0);

    rst_n = 1'b0; start = 1'b0; rd_en = 1'b0; key_mode = 2'b00; key_in = '0; rd_round = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset ready/busy/done", 128'({ready, busy, done}), 128'(3'b100));
    check("reset valid/err/hit", 128'({keys_valid, mode_err, rd_hit}), 128'(3'b000));
    check("reset nr_out", 128'(nr_out), 128'd0);
    check("reset rd_data", rd_data, 128'd0);
    rst_n = 1'b1;
    read_one(4'd0, 1'b0, 128'h0);

    // AES-128 load, table reads, hold behaviour
    load_key(2'b00, K128, 40, -1, "aes128");
    check("aes128 nr_out", 128'(nr_out), 128'd10);
    read_mode(2'b00);
    read_one(4'd10, 1'b1, R128_10);
    repeat (3) @(posedge clk);
    #1;
    check("rd_data hold", rd_data, R128_10);
    check("rd_hit hold", 128'(rd_hit), 128'd1);

    // illegal mode: pulse only, stored schedule untouched
    start = 1'b1; key_mode = 2'b11; key_in = K256;
    @(posedge clk); #1;
    start = 1'b0;
    check("mode_err pulse", 128'({mode_err, ready, busy, keys_valid}), 128'(4'b1101));
    check("mode_err nr_out", 128'(nr_out), 128'd10);
    @(posedge clk); #1;
    check("mode_err cleared", 128'(mode_err), 128'd0);
    read_one(4'd10, 1'b1, R128_10);

    // start during GEN is ignored
    load_key(2'b00, K128, 40, 10, "aes128 inject");
    check("inject nr_out", 128'(nr_out), 128'd10);
    read_one(4'd2, 1'b1, R128_2);
    read_one(4'd10, 1'b1, R128_10);

    // AES-192
    load_key(2'b01, K192, 46, -1, "aes192");
    check("aes192 nr_out", 128'(nr_out), 128'd12);
    read_mode(2'b01);

    // same-edge start and read sees the old schedule
    start = 1'b1; key_mode = 2'b10; key_in = K256;
    rd_en = 1'b1; rd_round = 4'd12;
    sb.push_back('{round: 4'd12, hit: 1'b1, data: R192_12});
    @(posedge clk); #1;
    start = 1'b0; rd_en = 1'b0;
    compare_out();
    check("collide busy/valid", 128'({busy, keys_valid}), 128'(2'b10));

    // reset in GEN cycle 20 aborts the schedule
    repeat (20) @(posedge clk);
    #1;
    check("pre-abort busy", 128'(busy), 128'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("abort ready/busy/valid", 128'({ready, busy, keys_valid}), 128'(3'b100));
    check("abort nr_out", 128'(nr_out), 128'd0);
    read_one(4'd0, 1'b0, 128'h0);

    // AES-256 rerun after abort
    load_key(2'b10, K256, 52, -1, "aes256");
    check("aes256 nr_out", 128'(nr_out), 128'd14);
    read_mode(2'b10);

    check("scoreboard drained", 128'(sb.size()), 128'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
